// File: rtl/ntt_pkg.sv
// Shared types, default constants and modular helpers for the iterative NTT core.
package ntt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BFLY   = 3'd1,
        NEXTST = 3'd2,
        SCALE  = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam int DEF_Q     = 65537;
    localparam int DEF_OMEGA = 13987;
    localparam int DEF_D_INV = 65025;

    // Reverse the low logd bits of idx.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int logd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < logd) r[5'(logd - 1 - i)] = idx[5'(i)];
        end
        return r;
    endfunction

    // (x + y) mod q for x, y < q.
    function automatic logic [31:0] mod_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[31:0];
    endfunction

    // (x - y) mod q for x, y < q.
    function automatic logic [31:0] mod_sub(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] q);
        if (x >= y) return x - y;
        return x - y + q;
    endfunction

endpackage

// File: rtl/ntt_iter_mod_mul.sv
// Combinational modular multiplier: p = x*y mod Q using the full 2N-bit product.
module mod_mul #(
    parameter int N = 17,
    parameter int Q = 65537
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] p
);
    localparam logic [2*N-1:0] QW = (2*N)'(Q);

    logic [2*N-1:0] prod;

    // Full-width product followed by a single reduction.
    always_comb begin
        prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        p    = N'(prod % QW);
    end
endmodule

// File: rtl/ntt_iter.sv
// Iterative DIF NTT/INTT core: one butterfly per cycle over an internal D-word array.
//
// state  | meaning
// IDLE   | waiting for start; captures mode and reduced coefficients
// BFLY   | one Gentleman-Sande butterfly per cycle, D/2 per stage
// NEXTST | square the stage root, halve the span, pick the next phase
// SCALE  | inverse only: multiply each word by D^-1, one per cycle
// OUT    | bit-reversed (and for inverse, index-negated) copy into b; pulse done
module ntt_iter
    import ntt_pkg::*;
#(
    parameter int N     = 17,
    parameter int D     = 128,
    parameter int Q     = DEF_Q,
    parameter int OMEGA = DEF_OMEGA,
    parameter int D_INV = DEF_D_INV
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [D*N-1:0] a,
    output logic           busy,
    output logic           done,
    output logic [D*N-1:0] b
);
    localparam int LOGD = $clog2(D);
    localparam logic [N-1:0] QN = N'(Q);

    typedef logic [LOGD-1:0] idx_t;

    state_t        state, state_n;
    logic          mode_r;
    logic [N-1:0]  x [D];
    logic [N-1:0]  wm, w;
    idx_t          len, cnt;

    idx_t          mask, j, lo, hi;
    logic [N-1:0]  u, v, sum_uv, dif_uv;
    logic [N-1:0]  prod_bf, prod_sh;
    logic [N-1:0]  mul_x, mul_y;

    // Butterfly addressing: cnt enumerates butterflies, split into group base and offset.
    always_comb begin
        mask   = len - idx_t'(1);
        j      = cnt & mask;
        lo     = ((cnt & ~mask) << 1) | j;
        hi     = lo | len;
        u      = x[lo];
        v      = x[hi];
        sum_uv = N'(mod_add(32'(u), 32'(v), 32'(Q)));
        dif_uv = N'(mod_sub(32'(u), 32'(v), 32'(Q)));
    end

    // The shared multiplier serves the twiddle step, the root square and the scaling.
    always_comb begin
        mul_x = w;
        mul_y = wm;
        case (state)
            NEXTST: begin
                mul_x = wm;
                mul_y = wm;
            end
            SCALE: begin
                mul_x = x[cnt];
                mul_y = N'(D_INV);
            end
            default: ;
        endcase
    end

    mod_mul #(.N(N), .Q(Q)) u_mul_bf (.x(dif_uv), .y(w), .p(prod_bf));
    mod_mul #(.N(N), .Q(Q)) u_mul_sh (.x(mul_x), .y(mul_y), .p(prod_sh));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BFLY;
            BFLY:    if (cnt == idx_t'(D/2 - 1)) state_n = NEXTST;
            NEXTST:  if (len == idx_t'(1)) state_n = mode_r ? SCALE : OUT;
                     else state_n = BFLY;
            SCALE:   if (cnt == idx_t'(D - 1)) state_n = OUT;
            OUT:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            b    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        for (int k = 0; k < D; k++) begin
                            x[k] <= (a[N*k +: N] >= QN) ? a[N*k +: N] - QN : a[N*k +: N];
                        end
                        wm   <= N'(OMEGA);
                        w    <= N'(1);
                        len  <= idx_t'(D/2);
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                BFLY: begin
                    x[lo] <= sum_uv;
                    x[hi] <= prod_bf;
                    cnt   <= cnt + idx_t'(1);
                    w     <= (j == mask) ? N'(1) : prod_sh;
                end
                NEXTST: begin
                    wm  <= prod_sh;
                    len <= len >> 1;
                    cnt <= '0;
                    w   <= N'(1);
                end
                SCALE: begin
                    x[cnt] <= prod_sh;
                    cnt    <= cnt + idx_t'(1);
                end
                OUT: begin
                    for (int k = 0; k < D; k++) begin
                        b[N*k +: N] <= x[idx_t'(bitrev(mode_r ? 32'((D - k) % D) : 32'(k), LOGD))];
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_iter.sv
// Directed bench for ntt_iter: table of transforms checked against a direct DFT model.
module tb_ntt_iter;
    localparam int N     = 17;
    localparam int D     = 128;
    localparam int Q     = 65537;
    localparam int OMEGA = 13987;
    localparam int D_INV = 65025;
    localparam int LOGD  = 7;
    localparam int LAT_F = LOGD * (D/2 + 1) + 1;
    localparam int LAT_I = LAT_F + D;
    localparam int NV    = 6;

    typedef logic [D*N-1:0] bus_t;
    typedef struct {
        string name;
        logic  mode;
        bus_t  a;
        bus_t  exp;
        int    lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, mode;
    bus_t a, b;
    logic busy, done;

    int    nvec = 0;
    int    nfail = 0;
    longint pw [D];
    vec_t  vecs [NV];
    bus_t  res  [NV];

    ntt_iter #(.N(N), .D(D), .Q(Q), .OMEGA(OMEGA), .D_INV(D_INV)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a),
        .busy(busy), .done(done), .b(b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Direct DFT: b_k = sum a_i w^(ik), inverse uses w^(-ik) and D^-1.
    function automatic bus_t ref_xform(input logic m, input bus_t av);
        longint ar [D];
        longint s;
        int     e;
        bus_t   r;
        for (int i = 0; i < D; i++) ar[i] = longint'(av[N*i +: N]) % Q;
        for (int k = 0; k < D; k++) begin
            s = 0;
            for (int i = 0; i < D; i++) begin
                e = (i * k) % D;
                if (m) e = (D - e) % D;
                s = (s + ar[i] * pw[e]) % Q;
            end
            if (m) s = (s * D_INV) % Q;
            r[N*k +: N] = N'(s);
        end
        return r;
    endfunction

    function automatic bus_t fill(input int v);
        bus_t r;
        for (int k = 0; k < D; k++) r[N*k +: N] = N'(v);
        return r;
    endfunction

    task automatic check_bus(input string name, input bus_t got, input bus_t exp);
        int idx;
        nvec++;
        if (got !== exp) begin
            idx = 0;
            for (int k = D - 1; k >= 0; k--) if (got[N*k +: N] !== exp[N*k +: N]) idx = k;
            nfail++;
            $display("FAIL %s: b[%0d]=%0d, required %0d", name, idx, got[N*idx +: N], exp[N*idx +: N]);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // One transform: accept, watch busy each cycle, optionally re-issue start mid-run.
    task automatic run(input string name, input logic m, input bus_t av, input bit poke,
                       input int exp_lat, output bus_t r);
        bit busy_ok;
        int lat;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        a     = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke) begin
                start = (lat >= 100 && lat < 104);
                mode  = ~m;
                a     = ~av;
            end
        end
        start = 1'b0;
        check_int({name, " latency"}, lat, exp_lat);
        check_int({name, " busy high"}, busy_ok, 1);
        check_int({name, " busy at done"}, busy, 0);
        r = b;
        @(posedge clk);
        #1;
        check_int({name, " done pulse"}, done, 0);
    endtask

    initial begin
        bus_t rnd, f, g, imp, tmp;

        pw[0] = 1;
        for (int e = 1; e < D; e++) pw[e] = (pw[e-1] * OMEGA) % Q;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset busy", busy, 0);
        check_int("reset done", done, 0);
        check_bus("reset b", b, '0);
        @(negedge clk);
        rst = 1'b0;

        imp = '0; imp[N*0 +: N] = N'(1);
        vecs[0].name = "impulse";   vecs[0].mode = 1'b0; vecs[0].a = imp;
        tmp = '0; tmp[N*1 +: N] = N'(1);
        vecs[1].name = "shift";     vecs[1].mode = 1'b0; vecs[1].a = tmp;
        vecs[2].name = "ones ntt";  vecs[2].mode = 1'b0; vecs[2].a = fill(1);
        tmp = '0; tmp[N*0 +: N] = N'(128);
        vecs[3].name = "ones intt"; vecs[3].mode = 1'b1; vecs[3].a = tmp;
        tmp = '0; tmp[N*0 +: N] = N'(65537);
        vecs[4].name = "reduce q";  vecs[4].mode = 1'b0; vecs[4].a = tmp;
        tmp = '0; tmp[N*0 +: N] = N'(131071);
        vecs[5].name = "reduce max"; vecs[5].mode = 1'b0; vecs[5].a = tmp;
        for (int i = 0; i < NV; i++) begin
            vecs[i].exp = ref_xform(vecs[i].mode, vecs[i].a);
            vecs[i].lat = vecs[i].mode ? LAT_I : LAT_F;
        end

        for (int i = 0; i < NV; i++) begin
            run(vecs[i].name, vecs[i].mode, vecs[i].a, 1'b0, vecs[i].lat, res[i]);
            check_bus({vecs[i].name, " result"}, res[i], vecs[i].exp);
        end

        check_bus("impulse all ones", res[0], fill(1));
        check_int("shift b0", res[1][N*0 +: N], 1);
        check_int("shift b1", res[1][N*1 +: N], 13987);
        check_int("shift b2", res[1][N*2 +: N], 8224);
        check_int("shift b64", res[1][N*64 +: N], 65536);
        tmp = '0; tmp[N*0 +: N] = N'(128);
        check_bus("ones ntt const", res[2], tmp);
        check_bus("ones intt const", res[3], fill(1));
        check_bus("reduce q const", res[4], '0);
        check_bus("reduce max const", res[5], fill(65534));

        for (int k = 0; k < D; k++) rnd[N*k +: N] = N'($urandom_range(0, Q - 1));
        run("rt ntt", 1'b0, rnd, 1'b0, LAT_F, f);
        check_bus("rt ntt result", f, ref_xform(1'b0, rnd));
        run("rt intt", 1'b1, f, 1'b1, LAT_I, g);
        check_bus("rt roundtrip", g, rnd);

        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = rnd;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_int("abort busy", busy, 0);
        check_int("abort done", done, 0);
        check_bus("abort b", b, '0);
        @(negedge clk);
        rst = 1'b0;
        run("post abort", 1'b0, imp, 1'b0, LAT_F, f);
        check_bus("post abort result", f, fill(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
